// File: rtl/if_stage_skid_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer, freeze (hazard hold) and flush (branch kill).
// The main slot drives out_* directly; an empty slot always holds PC=0 and the NOP encoding.
module if_stage_skid_reg #(
  parameter int unsigned          PC_W              = 32,
  parameter int unsigned          INSTR_W           = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR         = 32'hE0000000,
  parameter bit                   FLUSH_OVER_FREEZE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready depends only on registered state, freeze and rst.

  logic               r_main_valid;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_main_instr;
  logic               r_skid_valid;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;

  logic w_acc;
  logic w_pop;
  logic w_flush_act;
  logic w_main_free;

  assign in_ready    = !rst && !freeze && !r_skid_valid;
  assign w_acc       = in_valid && in_ready;
  assign w_pop       = r_main_valid && out_ready && !freeze;
  assign w_flush_act = flush && (FLUSH_OVER_FREEZE || !freeze);
  assign w_main_free = !r_main_valid || w_pop;

  always_ff @(posedge clk) begin
    if (rst || w_flush_act) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
    end else if (!freeze) begin
      if (w_main_free) begin
        // A full skid blocks in_ready, so refilling main from skid never races an accept.
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_pc    <= r_skid_pc;
          r_main_instr <= r_skid_instr;
          r_skid_valid <= 1'b0;
          r_skid_pc    <= '0;
          r_skid_instr <= NOP_INSTR;
        end else if (w_acc) begin
          r_main_valid <= 1'b1;
          r_main_pc    <= in_pc;
          r_main_instr <= in_instr;
        end else begin
          r_main_valid <= 1'b0;
          r_main_pc    <= '0;
          r_main_instr <= NOP_INSTR;
        end
      end else if (w_acc) begin
        r_skid_valid <= 1'b1;
        r_skid_pc    <= in_pc;
        r_skid_instr <= in_instr;
      end
    end
  end

  assign out_valid = r_main_valid;
  assign out_pc    = r_main_pc;
  assign out_instr = r_main_instr;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_if_stage_skid_reg.sv
// Directed bench for if_stage_skid_reg; a second instance with FLUSH_OVER_FREEZE=0 shares all inputs.
module tb_if_stage_skid_reg;

  localparam logic [31:0] NOP = 32'hE0000000;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_pc, a_out_instr, b_out_pc, b_out_instr;
  logic [1:0]  a_occ, b_occ;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  if_stage_skid_reg #(.FLUSH_OVER_FREEZE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_instr(a_out_instr), .occupancy(a_occ)
  );

  if_stage_skid_reg #(.FLUSH_OVER_FREEZE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_instr(b_out_instr), .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h00000013 | (pc << 8);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_pc    = '0;
    in_instr = '0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [1:0] occ);
    check({tag, ".valid"}, a_out_valid, 1'b1);
    check({tag, ".pc"}, a_out_pc, pc);
    check({tag, ".instr"}, a_out_instr, instr_of(pc));
    check({tag, ".occ"}, a_occ, occ);
  endtask

  task automatic expect_bubble(input string tag);
    check({tag, ".valid"}, a_out_valid, 1'b0);
    check({tag, ".pc"}, a_out_pc, 32'd0);
    check({tag, ".instr"}, a_out_instr, NOP);
    check({tag, ".occ"}, a_occ, 2'd0);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle_in();
    step();
    step();
    expect_bubble("reset");
    check("reset.in_ready", a_in_ready, 1'b0);

    // 1: streaming with out_ready high, one-cycle latency
    rst = 1'b0; out_ready = 1'b1;
    offer(32'd4);
    #1 check("t1.in_ready", a_in_ready, 1'b1);
    step(); expect_out("t1.pc4", 32'd4, 2'd1);
    offer(32'd8);
    step(); expect_out("t1.pc8", 32'd8, 2'd1);
    offer(32'd12);
    step(); expect_out("t1.pc12", 32'd12, 2'd1);
    idle_in();
    step(); expect_bubble("t1.drain");

    // 2: backpressure fills the skid slot, then drains in order
    out_ready = 1'b0;
    offer(32'd4);
    step(); expect_out("t2.a", 32'd4, 2'd1);
    offer(32'd8);
    step(); expect_out("t2.b", 32'd4, 2'd2);
    check("t2.in_ready_full", a_in_ready, 1'b0);
    offer(32'd12);
    step(); expect_out("t2.hold", 32'd4, 2'd2);
    out_ready = 1'b1;
    step(); expect_out("t2.pop8", 32'd8, 2'd1);
    check("t2.in_ready_free", a_in_ready, 1'b1);
    step(); expect_out("t2.pop12", 32'd12, 2'd1);
    idle_in();
    step(); expect_bubble("t2.drain");

    // 3: flush with both slots full, then flush discarding an accepted input
    out_ready = 1'b0;
    offer(32'd20); step();
    offer(32'd24); step();
    check("t3.occ_full", a_occ, 2'd2);
    offer(32'd28); flush = 1'b1;
    step(); expect_bubble("t3.flush");
    check("t3.in_ready", a_in_ready, 1'b1);
    flush = 1'b0;
    offer(32'd32); step();
    check("t3.occ1", a_occ, 2'd1);
    offer(32'd36); flush = 1'b1;
    #1 check("t3.in_ready_hi", a_in_ready, 1'b1);
    step(); expect_bubble("t3.flush_discard");
    flush = 1'b0;

    // 4: freeze holds everything despite out_ready and in_valid
    offer(32'd40); step();
    out_ready = 1'b1; freeze = 1'b1;
    offer(32'd44);
    for (int i = 0; i < 3; i++) begin
      #1 check("t4.in_ready", a_in_ready, 1'b0);
      step(); expect_out("t4.frozen", 32'd40, 2'd1);
    end
    freeze = 1'b0;
    step(); expect_out("t4.resume", 32'd44, 2'd1);

    // 5: freeze and flush together, per FLUSH_OVER_FREEZE
    idle_in(); out_ready = 1'b0; freeze = 1'b1; flush = 1'b1;
    step();
    expect_bubble("t5.a");
    check("t5.b_valid", b_out_valid, 1'b1);
    check("t5.b_pc", b_out_pc, 32'd44);
    check("t5.b_instr", b_out_instr, instr_of(32'd44));
    check("t5.b_occ", b_occ, 2'd1);
    freeze = 1'b0;
    step();
    check("t5.b_flushed_valid", b_out_valid, 1'b0);
    check("t5.b_flushed_occ", b_occ, 2'd0);
    flush = 1'b0;

    // 6: reset mid-stream with both slots full
    offer(32'd60); step();
    offer(32'd64); step();
    check("t6.occ_full", a_occ, 2'd2);
    rst = 1'b1;
    step(); expect_bubble("t6.reset");
    check("t6.in_ready_rst", a_in_ready, 1'b0);
    rst = 1'b0;
    #1 check("t6.in_ready_rel", a_in_ready, 1'b1);
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
